matmul_seq_ctrl: RTL

- Sequencing FSM for the matrix-multiply datapath. It computes C = A x B for N x N matrices.
- It walks i/j/k indices and issues the element read addresses for A and B.
- It drives accumulator clear and enable strobes and the result-regfile write strobe.
- It reports progress and completion to the top-level through a start/busy/done handshake.

---
 rtl/matmul_pkg.sv | 17 +
 rtl/mm_index_counter.sv | 51 +++++
 rtl/matmul_seq_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// Holds the FSM state enum, address/counter widths and max dimension.
package matmul_pkg;
  localparam int MAX_N  = 4;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    DRAIN,
    WR,
    DONE
  } state_t;
endpackage

// File: rtl/mm_index_counter.sv
// Nested i/j/k index counter for the matmul sequencer.
// Ports: clr_ij/clr_k clear, inc_k/inc_ij step; i,j,k plus last flags out.
module mm_index_counter
  import matmul_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_ij,
  input  logic             clr_k,
  input  logic             inc_k,
  input  logic             inc_ij,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             k_last,
  output logic             ij_last
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic j_last;

  assign k_last  = (k == LAST);
  assign j_last  = (j == LAST);
  assign ij_last = (i == LAST) && j_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (clr_k)
        k <= '0;
      else if (inc_k)
        k <= k + IDX_W'(1);
      if (clr_ij) begin
        i <= '0;
        j <= '0;
      end else if (inc_ij) begin
        if (j_last) begin
          j <= '0;
          i <= i + IDX_W'(1);
        end else begin
          j <= j + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencing FSM for C = A x B: walks i/j/k, issues A/B reads, C writes.
// Ports: start/abort in; busy/done, rd/acc/wr strobes, addresses, entry_cnt out.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CNT_W-1:0]  entry_cnt
);
  localparam logic [ADDR_W-1:0] NA = ADDR_W'(N);

  state_t           state;
  logic [IDX_W-1:0] i, j, k;
  logic             k_last, ij_last;
  logic             clr_ij, clr_k, inc_k, inc_ij;

  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);
  assign rd_en   = (state == MAC);
  assign acc_clr = (state == CLR);
  assign wr_en   = (state == WR);

  assign clr_ij = (state == IDLE) && start && !abort;
  assign clr_k  = (state == CLR);
  assign inc_k  = (state == MAC) && !k_last;
  assign inc_ij = (state == WR) && !ij_last && !abort;

  assign a_addr  = ADDR_W'(i) * NA + ADDR_W'(k);
  assign b_addr  = ADDR_W'(k) * NA + ADDR_W'(j);
  assign wr_addr = ADDR_W'(i) * NA + ADDR_W'(j);

  mm_index_counter #(.N(N)) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clr_ij  (clr_ij),
    .clr_k   (clr_k),
    .inc_k   (inc_k),
    .inc_ij  (inc_ij),
    .i       (i),
    .j       (j),
    .k       (k),
    .k_last  (k_last),
    .ij_last (ij_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc_en    <= 1'b0;
      entry_cnt <= '0;
    end else begin
      // Data returns one cycle after the read; abort kills the tail.
      acc_en <= rd_en && !abort;
      if (abort && busy) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:
            if (start && !abort) begin
              state     <= CLR;
              entry_cnt <= '0;
            end
          CLR:   state <= MAC;
          MAC:   if (k_last) state <= DRAIN;
          DRAIN: state <= WR;
          WR: begin
            entry_cnt <= entry_cnt + CNT_W'(1);
            state     <= ij_last ? DONE : CLR;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
